// File: rtl/job_seq_pkg.sv
// rtl/job_seq_pkg.sv - shared opcodes, states and error-code bit positions for the job sequencer
package job_seq_pkg;

    localparam logic [7:0] JOB_RESET = 8'h80;
    localparam logic [7:0] JOB_START = 8'h90;

    localparam int ERR_TIMEOUT_BIT = 62;
    localparam int ERR_RSVD_BIT    = 63;

    typedef enum logic [1:0] {
        IDLE,
        RUNNING,
        FINISH
    } job_state_e;

endpackage

// File: rtl/afu_job_sequencer_if.sv
// rtl/afu_job_sequencer_if.sv - PSL job interface plus work-element channel fan-out bundle
interface afu_job_sequencer_if #(
    parameter int NUM_CHANNELS  = 4,
    parameter int TIMEOUT_WIDTH = 32
);
    logic                     job_valid;
    logic [7:0]               job_command;
    logic [63:0]              job_address;
    logic [TIMEOUT_WIDTH-1:0] timeout_limit;
    logic [NUM_CHANNELS-1:0]  ch_done;
    logic [NUM_CHANNELS-1:0]  ch_error;
    logic                     job_running;
    logic                     job_done;
    logic [63:0]              job_error;
    logic                     job_cack;
    logic                     job_yield;
    logic [NUM_CHANNELS-1:0]  ch_enable;
    logic                     ch_reset;
    logic [63:0]              ch_wed;

    modport master (
        output job_valid, job_command, job_address, timeout_limit, ch_done, ch_error,
        input  job_running, job_done, job_error, job_cack, job_yield, ch_enable, ch_reset, ch_wed
    );

    modport slave (
        input  job_valid, job_command, job_address, timeout_limit, ch_done, ch_error,
        output job_running, job_done, job_error, job_cack, job_yield, ch_enable, ch_reset, ch_wed
    );
endinterface

// File: rtl/done_delay_line.sv
// rtl/done_delay_line.sv - fixed-latency shift register carrying done events and their error codes
module done_delay_line #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 64
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             i_valid,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_data
);
    logic [DEPTH-1:0] r_valid;
    logic [WIDTH-1:0] r_data [DEPTH];

    always_ff @(posedge clock) begin
        if (reset) begin
            r_valid <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_data[i] <= '0;
            end
        end else begin
            r_valid[0] <= i_valid;
            r_data[0]  <= i_data;
            for (int i = 1; i < DEPTH; i++) begin
                r_valid[i] <= r_valid[i-1];
                r_data[i]  <= r_data[i-1];
            end
        end
    end

    assign o_valid = r_valid[DEPTH-1];
    assign o_data  = r_data[DEPTH-1];
endmodule

// File: rtl/afu_job_sequencer.sv
// rtl/afu_job_sequencer.sv - decodes PSL job commands, fans a job out to channels, reports delayed done/error
module afu_job_sequencer
    import job_seq_pkg::*;
#(
    parameter int NUM_CHANNELS  = 4,
    parameter int DONE_DELAY    = 2,
    parameter int TIMEOUT_WIDTH = 32
) (
    input logic                clock,
    input logic                reset,
    afu_job_sequencer_if.slave bus
);
    job_state_e               r_state;
    job_state_e               w_state_next;
    logic [NUM_CHANNELS-1:0]  r_done_mask;
    logic [NUM_CHANNELS-1:0]  r_err_mask;
    logic [TIMEOUT_WIDTH-1:0] r_watchdog;
    logic [63:0]              r_wed;
    logic                     r_ch_reset;
    logic                     r_evt_valid;
    logic [63:0]              r_evt_err;

    logic                     w_cmd_start;
    logic                     w_cmd_reset;
    logic [NUM_CHANNELS-1:0]  w_done_next;
    logic [NUM_CHANNELS-1:0]  w_err_next;
    logic                     w_all_done;
    logic                     w_any_err;
    logic                     w_timeout;
    logic                     w_finish;
    logic                     w_evt_valid;
    logic [63:0]              w_evt_err;

    assign w_cmd_start = bus.job_valid && (bus.job_command == JOB_START);
    assign w_cmd_reset = bus.job_valid && (bus.job_command == JOB_RESET);
    assign w_done_next = r_done_mask | bus.ch_done;
    assign w_err_next  = r_err_mask | bus.ch_error;
    assign w_all_done  = &w_done_next;
    assign w_any_err   = |w_err_next;
    assign w_timeout   = (bus.timeout_limit != '0) &&
                         (r_watchdog == bus.timeout_limit - TIMEOUT_WIDTH'(1));
    assign w_finish    = (r_state == RUNNING) && (w_all_done || w_any_err || w_timeout);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // RESET command overrides every same-cycle completion source, including its event code.
    always_comb begin
        w_state_next = r_state;
        w_evt_valid  = 1'b0;
        w_evt_err    = '0;
        if (w_cmd_reset) begin
            w_state_next = IDLE;
            w_evt_valid  = 1'b1;
        end else begin
            case (r_state)
                IDLE:    if (w_cmd_start) w_state_next = RUNNING;
                RUNNING: if (w_finish) begin
                    w_state_next                    = FINISH;
                    w_evt_valid                     = 1'b1;
                    w_evt_err[NUM_CHANNELS-1:0]     = w_err_next;
                    w_evt_err[ERR_TIMEOUT_BIT]      = w_timeout && !w_any_err && !w_all_done;
                    w_evt_err[ERR_RSVD_BIT]         = 1'b0;
                end
                FINISH:  w_state_next = IDLE;
                default: w_state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_done_mask <= '0;
            r_err_mask  <= '0;
            r_watchdog  <= '0;
            r_wed       <= '0;
            r_ch_reset  <= 1'b0;
            r_evt_valid <= 1'b0;
            r_evt_err   <= '0;
        end else begin
            r_ch_reset  <= w_cmd_reset;
            r_evt_valid <= w_evt_valid;
            r_evt_err   <= w_evt_err;
            if (w_cmd_reset) begin
                r_done_mask <= '0;
                r_err_mask  <= '0;
                r_watchdog  <= '0;
            end else if (r_state == IDLE && w_cmd_start) begin
                r_done_mask <= '0;
                r_err_mask  <= '0;
                r_watchdog  <= '0;
                r_wed       <= bus.job_address;
            end else if (r_state == RUNNING) begin
                r_done_mask <= w_done_next;
                r_err_mask  <= w_err_next;
                if (r_watchdog != '1) begin
                    r_watchdog <= r_watchdog + TIMEOUT_WIDTH'(1);
                end
            end
        end
    end

    done_delay_line #(
        .DEPTH (DONE_DELAY),
        .WIDTH (64)
    ) u_done_delay (
        .clock   (clock),
        .reset   (reset),
        .i_valid (r_evt_valid),
        .i_data  (r_evt_err),
        .o_valid (bus.job_done),
        .o_data  (bus.job_error)
    );

    assign bus.job_running = (r_state == RUNNING);
    assign bus.ch_enable   = (r_state == RUNNING) ? ~r_done_mask : '0;
    assign bus.ch_reset    = r_ch_reset;
    assign bus.ch_wed      = r_wed;
    assign bus.job_cack    = 1'b0;
    assign bus.job_yield   = 1'b0;
endmodule

// File: tb/tb_afu_job_sequencer.sv
// tb/tb_afu_job_sequencer.sv - scoreboard bench: directed job scenarios then randomized traffic vs a job-level model
module tb_afu_job_sequencer;
    import job_seq_pkg::*;

    localparam int NCH = 4;
    localparam int DD  = 2;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    afu_job_sequencer_if #(.NUM_CHANNELS(NCH), .TIMEOUT_WIDTH(32)) bus ();

    afu_job_sequencer #(
        .NUM_CHANNELS  (NCH),
        .DONE_DELAY    (DD),
        .TIMEOUT_WIDTH (32)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic            running;
        logic [NCH-1:0]  en;
        logic [63:0]     wed;
        logic            chr;
    } exp_t;

    typedef struct {
        int          due;
        logic [63:0] code;
    } ev_t;

    exp_t exp_q[$];
    ev_t  done_q[$];

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    // Job-level reference: is a job live, which channels reported, how long it has run.
    bit           m_running  = 0;
    bit           m_finish   = 0;
    bit [NCH-1:0] m_done     = '0;
    bit [NCH-1:0] m_err      = '0;
    longint       m_elapsed  = 0;
    logic [63:0]  m_wed      = '0;
    logic [31:0]  cur_lim    = '0;

    task automatic model_step();
        exp_t        e;
        ev_t         ev;
        bit          timed;
        bit          is_reset_cmd;
        bit          is_start_cmd;
        e.chr        = 1'b0;
        is_reset_cmd = bus.job_valid && bus.job_command == JOB_RESET;
        is_start_cmd = bus.job_valid && bus.job_command == JOB_START;
        if (reset) begin
            m_running = 0; m_finish = 0; m_done = '0; m_err = '0; m_elapsed = 0; m_wed = '0;
            done_q.delete();
        end else if (is_reset_cmd) begin
            e.chr = 1'b1;
            m_running = 0; m_finish = 0; m_done = '0; m_err = '0;
            ev.due = cyc + 1 + DD; ev.code = '0;
            done_q.push_back(ev);
        end else if (m_running) begin
            timed  = (cur_lim != 0) && (m_elapsed == longint'(cur_lim) - 1);
            m_done = m_done | bus.ch_done;
            m_err  = m_err | bus.ch_error;
            m_elapsed++;
            if (m_err != 0 || m_done == '1 || timed) begin
                ev.due  = cyc + 1 + DD;
                ev.code = '0;
                if (m_err != 0) ev.code = 64'(m_err);
                else if (m_done != '1) ev.code = 64'h4000_0000_0000_0000;
                done_q.push_back(ev);
                m_running = 0;
                m_finish  = 1;
            end
        end else if (m_finish) begin
            m_finish = 0;
        end else if (is_start_cmd) begin
            m_running = 1; m_done = '0; m_err = '0; m_elapsed = 0;
            m_wed = bus.job_address;
        end
        e.running = m_running;
        e.en      = m_running ? ~m_done : '0;
        e.wed     = m_wed;
        exp_q.push_back(e);
    endtask

    task automatic step(input bit rst, input bit v, input logic [7:0] cmd,
                        input logic [63:0] addr, input logic [NCH-1:0] d, input logic [NCH-1:0] er);
        reset             = rst;
        bus.job_valid     = v;
        bus.job_command   = cmd;
        bus.job_address   = addr;
        bus.timeout_limit = cur_lim;
        bus.ch_done       = d;
        bus.ch_error      = er;
        model_step();
        @(negedge clock);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 8'h00, 64'h0, '0, '0);
    endtask

    task automatic start(input logic [63:0] addr);
        step(0, 1, JOB_START, addr, '0, '0);
    endtask

    initial begin : monitor
        exp_t e;
        ev_t  ev;
        bit   exp_done;
        forever begin
            @(posedge clock);
            cyc++;
            #1;
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL exp_queue cyc=%0d no expectation queued", cyc);
            end else begin
                e = exp_q.pop_front();
                if (bus.job_running !== e.running || bus.ch_enable !== e.en || bus.ch_wed !== e.wed ||
                    bus.ch_reset !== e.chr || bus.job_cack !== 1'b0 || bus.job_yield !== 1'b0) begin
                    n_bad++;
                    $display("FAIL outputs cyc=%0d got run=%b en=%b wed=%h chr=%b cack=%b yld=%b want run=%b en=%b wed=%h chr=%b cack=0 yld=0",
                             cyc, bus.job_running, bus.ch_enable, bus.ch_wed, bus.ch_reset, bus.job_cack,
                             bus.job_yield, e.running, e.en, e.wed, e.chr);
                end
            end
            exp_done = (done_q.size() > 0) && (done_q[0].due == cyc);
            n_cmp++;
            if (bus.job_done !== exp_done) begin
                n_bad++;
                $display("FAIL job_done cyc=%0d got %b want %b", cyc, bus.job_done, exp_done);
            end
            if (exp_done) begin
                ev = done_q.pop_front();
                if (bus.job_done === 1'b1) begin
                    n_cmp++;
                    if (bus.job_error !== ev.code) begin
                        n_bad++;
                        $display("FAIL job_error cyc=%0d got %h want %h", cyc, bus.job_error, ev.code);
                    end
                end
            end
        end
    end

    initial begin : driver
        logic [7:0]     cmd;
        logic [NCH-1:0] d;
        logic [NCH-1:0] er;
        int             r;
        step(1, 0, 8'h00, 64'h0, '0, '0);
        step(1, 0, 8'h00, 64'h0, '0, '0);
        idle(2);

        // Two-phase completion.
        start(64'h1000); idle(4);
        step(0, 0, 8'h00, 64'h0, 4'b0011, '0); idle(2);
        step(0, 0, 8'h00, 64'h0, 4'b1100, '0); idle(5);

        // Channel error mid-run.
        start(64'h2000); idle(5);
        step(0, 0, 8'h00, 64'h0, '0, 4'b0100); idle(5);

        // Watchdog expiry.
        cur_lim = 10;
        start(64'h3000); idle(15);
        cur_lim = 0;

        // RESET command colliding with full completion.
        start(64'h4000); idle(2);
        step(0, 1, JOB_RESET, 64'h0, 4'b1111, '0); idle(5);

        // Synchronous reset one cycle before the done pulse.
        start(64'h5000); idle(1);
        step(0, 0, 8'h00, 64'h0, 4'b1111, '0);
        step(1, 0, 8'h00, 64'h0, '0, '0); idle(5);

        // START while running and while finishing, plus an unknown opcode.
        start(64'h6000); idle(2);
        step(0, 1, JOB_START, 64'hDEAD, 4'b0001, '0); idle(1);
        step(0, 0, 8'h00, 64'h0, 4'b1110, '0);
        step(0, 1, JOB_START, 64'hBEEF, '0, '0); idle(3);
        step(0, 1, 8'h91, 64'h7777, '0, '0); idle(2);

        // Error wins over last done; all-done wins over timeout.
        start(64'h7000); idle(1);
        step(0, 0, 8'h00, 64'h0, 4'b0111, '0);
        step(0, 0, 8'h00, 64'h0, 4'b1000, 4'b0001); idle(4);
        cur_lim = 5;
        start(64'h8000); idle(4);
        step(0, 0, 8'h00, 64'h0, 4'b1111, '0); idle(4);

        for (int i = 0; i < 3000; i++) begin
            if (i % 64 == 0) cur_lim = ($urandom_range(0, 2) == 0) ? 32'd0 : 32'($urandom_range(3, 25));
            r = $urandom_range(0, 99);
            if (r < 60) cmd = JOB_START;
            else if (r < 75) cmd = JOB_RESET;
            else begin
                cmd = 8'($urandom_range(0, 255));
                if (cmd == JOB_START || cmd == JOB_RESET) cmd = 8'h00;
            end
            for (int b = 0; b < NCH; b++) d[b] = ($urandom_range(0, 5) == 0);
            er = '0;
            if ($urandom_range(0, 79) == 0) er[$urandom_range(0, NCH-1)] = 1'b1;
            step($urandom_range(0, 299) == 0, $urandom_range(0, 7) == 0, cmd,
                 {$urandom, $urandom}, d, er);
        end
        idle(DD + 4);

        n_cmp++;
        if (done_q.size() != 0) begin
            n_bad++;
            $display("FAIL pending_done got %0d outstanding want 0", done_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
